// File: rtl/regfile_read_arbiter_pkg.sv
// Shared types and constants for the register-file read-port arbiter.
package rf_arb_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 64;
  localparam int RF_ID_W   = 3;  // wide enough for the largest NREQ (8)

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;

  localparam rf_addr_t XZR_ADDR = rf_addr_t'(31);

  typedef struct packed {
    logic               valid;
    logic [RF_ID_W-1:0] id;
    rf_addr_t           addr;
  } s1_t;

endpackage

// File: rtl/regfile_read_arbiter_rr_picker.sv
// Combinational round-robin picker: first set bit of req at or after ptr, wrapping modulo NREQ.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_id
);

  logic [ID_W:0] idx;
  logic          found;

  // NOTE: every output of a combinational block gets a default before the scan so no latch is inferred.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr} + (ID_W+1)'(i);
      if (idx >= (ID_W+1)'(NREQ)) idx = idx - (ID_W+1)'(NREQ);
      if (!found && req[idx[ID_W-1:0]]) begin
        found  = 1'b1;
        gnt_id = idx[ID_W-1:0];
      end
    end
    if (found) gnt[gnt_id] = 1'b1;
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Round-robin sharing of the 32x64 register-file read mux; two-stage tagged response pipeline.
// Optional build macro: RF_ARB_XZR_EN (reads of X31 return zero).
module regfile_read_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  output logic [NREQ-1:0]          req_ready,
  output logic [ADDR_W-1:0]        rf_sel,
  input  logic [DATA_W-1:0]        rf_data,
  output logic                     rsp_valid,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [DATA_W-1:0]        rsp_data
);

  localparam int ID_W = $clog2(NREQ);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] gnt_id;
  logic            any_req;
  rf_addr_t        win_addr;
  rf_data_t        rd_data;
  s1_t             s1;
  logic            unused_id_hi;

  rr_picker #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_picker (
    .req    (req_valid),
    .ptr    (ptr),
    .gnt    (req_ready),
    .gnt_id (gnt_id)
  );

  assign any_req      = |req_valid;
  assign win_addr     = req_addr[gnt_id*ADDR_W +: ADDR_W];
  assign rf_sel       = s1.addr;
  assign unused_id_hi = ^s1.id;

`ifdef RF_ARB_XZR_EN
  assign rd_data = (s1.addr == XZR_ADDR) ? '0 : rf_data;
`else
  assign rd_data = rf_data;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      s1        <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      s1.valid <= any_req;
      // Address only reloads on a grant so the mux select stays quiet when idle.
      if (any_req) begin
        s1.id   <= RF_ID_W'(gnt_id);
        s1.addr <= win_addr;
        ptr     <= (gnt_id == ID_W'(NREQ-1)) ? '0 : gnt_id + 1'b1;
      end
      rsp_valid <= s1.valid;
      if (s1.valid) begin
        rsp_id   <= s1.id[ID_W-1:0];
        rsp_data <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Randomized and directed bench for regfile_read_arbiter against a queue-based reference model.
module tb_regfile_read_arbiter;

  localparam int NREQ   = 4;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 64;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*ADDR_W-1:0]  req_addr;
  logic [NREQ-1:0]         req_ready;
  logic [ADDR_W-1:0]       rf_sel;
  logic [DATA_W-1:0]       rf_data;
  logic                    rsp_valid;
  logic [1:0]              rsp_id;
  logic [DATA_W-1:0]       rsp_data;

  regfile_read_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rf_sel    (rf_sel),
    .rf_data   (rf_data),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  always #5 clk = ~clk;

  // Behavioural register-file mux: X31 reads all ones, others 0xDEAD_00nn.
  function automatic logic [DATA_W-1:0] mux_val(input int sel);
    if (sel == 31) return '1;
    return 64'hDEAD_0000 + 64'(sel);
  endfunction

  always_comb rf_data = mux_val(int'(rf_sel));

  function automatic logic [DATA_W-1:0] exp_data(input int addr);
`ifdef RF_ARB_XZR_EN
    if (addr == 31) return '0;
`endif
    return mux_val(addr);
  endfunction

  typedef struct {
    int due;
    int id;
    int addr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   m_ptr    = 0;
  int   m_sel    = 0;
  int   rsp1_cnt = 0;
  int   ready_log[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic int winner(input logic [NREQ-1:0] v, input int p);
    for (int i = 0; i < NREQ; i++)
      if (v[(p + i) % NREQ]) return (p + i) % NREQ;
    return -1;
  endfunction

  function automatic int addr_of(input int k);
    logic [NREQ*ADDR_W-1:0] a;
    a = req_addr;
    return int'(a[k*ADDR_W +: ADDR_W]);
  endfunction

  // One clock: check outputs at the falling edge, advance the model at the rising edge.
  task automatic tick();
    int w;
    @(negedge clk);
    w = winner(req_valid, m_ptr);
    check("req_ready", 64'(req_ready), (w < 0) ? 64'd0 : 64'(1) << w);
    ready_log.push_back(int'(req_ready));
    check("rf_sel", 64'(rf_sel), 64'(m_sel));
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      check("rsp_valid", 64'(rsp_valid), 64'd1);
      check("rsp_id", 64'(rsp_id), 64'(exp_q[0].id));
      check("rsp_data", rsp_data, exp_data(exp_q[0].addr));
      void'(exp_q.pop_front());
    end else begin
      check("rsp_idle", 64'(rsp_valid), 64'd0);
    end
    if (rsp_valid && rsp_id == 2'd1) rsp1_cnt++;
    @(posedge clk);
    if (reset) begin
      exp_q.delete();
      m_ptr = 0;
      m_sel = 0;
    end else if (w >= 0) begin
      exp_q.push_back('{due: cyc + 2, id: w, addr: addr_of(w)});
      m_sel = addr_of(w);
      m_ptr = (w + 1) % NREQ;
    end
    cyc++;
    #1;
  endtask

  task automatic set_req(input logic [NREQ-1:0] v, input logic [NREQ*ADDR_W-1:0] a);
    req_valid = v;
    req_addr  = a;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) tick();
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    set_req('0, '0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    set_req('0, '0);
    #1;
    do_reset(3);
    idle(2);

    // Single request: requester 2 reads X5.
    set_req(4'b0100, {5'd0, 5'd5, 5'd0, 5'd0});
    tick();
    idle(3);

    // All four requesters for 8 cycles from ptr 0.
    do_reset(1);
    ready_log.delete();
    set_req(4'b1111, {5'd13, 5'd12, 5'd11, 5'd10});
    for (int i = 0; i < 8; i++) tick();
    for (int i = 0; i < 8; i++) check("rotate_order", 64'(ready_log[i]), 64'(1) << (i % 4));
    idle(3);

    // Pointer wrap after a grant to requester 3, then 1 beats 3.
    set_req(4'b1000, {5'd7, 5'd0, 5'd0, 5'd0});
    tick();
    ready_log.delete();
    set_req(4'b1010, {5'd9, 5'd0, 5'd8, 5'd0});
    tick();
    check("wrap_pick1", 64'(ready_log[0]), 64'b0010);
    idle(3);

    // Reset the cycle after two grants discards in-flight reads.
    set_req(4'b0011, {5'd0, 5'd0, 5'd21, 5'd20});
    tick();
    tick();
    reset = 1'b1;
    set_req(4'b1111, {5'd3, 5'd3, 5'd3, 5'd3});
    tick();
    reset = 1'b0;
    idle(4);

    // XZR read by requester 0.
    set_req(4'b0001, {5'd0, 5'd0, 5'd0, 5'd31});
    tick();
    idle(3);

    // Withdrawn request: requester 1 shows up once while 0 is granted.
    do_reset(1);
    rsp1_cnt = 0;
    set_req(4'b0011, {5'd0, 5'd0, 5'd17, 5'd16});
    tick();
    set_req(4'b0001, {5'd0, 5'd0, 5'd0, 5'd16});
    tick();
    tick();
    idle(4);
    check("withdraw_no_rsp1", 64'(rsp1_cnt), 64'd0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      set_req(NREQ'($urandom), (NREQ*ADDR_W)'($urandom));
      reset = ($urandom_range(0, 39) == 0);
      tick();
    end
    reset = 1'b0;
    idle(4);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
